// File: rtl/ifmap_row_tagger_pkg.sv
// Shared types and constants for the IFMap row tagger and its row/column counter.
package ifmap_row_tagger_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 8;

    // Tag bit positions within the output word for the default data width.
    localparam int START_BIT = DEF_DATA_WIDTH + 1;
    localparam int END_BIT   = DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } tagger_state_t;

endpackage

// File: rtl/ifmap_row_tagger_row_col_counter.sv
// Column/row position tracker for a framed stream. The column wraps at
// row_len-1 and the row advances on each wrap. Flags describe the position
// of the word about to be accepted, so callers tag it in the same cycle.
module row_col_counter
    import ifmap_row_tagger_pkg::*;
#(
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_advance,
    input  logic [LEN_WIDTH-1:0] i_row_len,
    input  logic [LEN_WIDTH-1:0] i_num_rows,
    output logic                 o_first_col,
    output logic                 o_last_col,
    output logic                 o_last_word
);

    localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [LEN_WIDTH-1:0] r_col;
    logic [LEN_WIDTH-1:0] r_row;
    logic                 w_last_col;
    logic                 w_last_row;

    assign w_last_col = (r_col == (i_row_len - ONE));
    assign w_last_row = (r_row == (i_num_rows - ONE));

    assign o_first_col = (r_col == '0);
    assign o_last_col  = w_last_col;
    assign o_last_word = w_last_col && w_last_row;

    // Advance position on each accepted word; the row wraps to 0 after the
    // final word so the counters never run past the configured frame.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_advance) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : (r_row + ONE);
            end else begin
                r_col <= r_col + ONE;
            end
        end
    end

endmodule

// File: rtl/ifmap_row_tagger.sv
// Frames a raw activation stream into rows, tags start/end of row and
// forwards each tagged word into the IFMap FIFO through a one-word output
// register that sustains one word per cycle while the FIFO has room.
module ifmap_row_tagger
    import ifmap_row_tagger_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_cfg_row_len,
    input  logic [LEN_WIDTH-1:0]  i_cfg_num_rows,
    input  logic                  i_pix_valid,
    input  logic [DATA_WIDTH-1:0] i_pix_data,
    output logic                  o_pix_ready,
    input  logic                  i_buf_ready,
    output logic [DATA_WIDTH+1:0] o_ifmap_data,
    output logic                  o_ifmap_wen,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err
);

    tagger_state_t         r_state;
    logic [LEN_WIDTH-1:0]  r_row_len;
    logic [LEN_WIDTH-1:0]  r_num_rows;
    logic                  r_out_valid;
    logic [DATA_WIDTH+1:0] r_out_word;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cfg_err;

    logic w_pix_ready;
    logic w_accept;
    logic w_wen;
    logic w_cfg_ok;
    logic w_launch;
    logic w_first_col;
    logic w_last_col;
    logic w_last_word;

    // The output register may take a new word whenever it is empty or is
    // being drained this same cycle.
    assign w_pix_ready = (r_state == ST_STREAM) && (!r_out_valid || i_buf_ready);
    assign w_accept    = i_pix_valid && w_pix_ready;
    assign w_wen       = r_out_valid && i_buf_ready;
    assign w_cfg_ok    = (i_cfg_row_len != '0) && (i_cfg_num_rows != '0);
    assign w_launch    = (r_state == ST_IDLE) && i_start && w_cfg_ok;

    row_col_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_row_col_counter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_launch),
        .i_advance   (w_accept),
        .i_row_len   (r_row_len),
        .i_num_rows  (r_num_rows),
        .o_first_col (w_first_col),
        .o_last_col  (w_last_col),
        .o_last_word (w_last_word)
    );

    assign o_pix_ready  = w_pix_ready;
    assign o_ifmap_wen  = w_wen;
    assign o_ifmap_data = r_out_word;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_cfg_err    = r_cfg_err;

    // Frame sequencing, output word register and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_row_len   <= '0;
            r_num_rows  <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;

            // A same-cycle accept and write simply replaces the held word.
            if (w_accept) begin
                r_out_word  <= {w_first_col, w_last_col, i_pix_data};
                r_out_valid <= 1'b1;
            end else if (w_wen) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_cfg_ok) begin
                            r_row_len  <= i_cfg_row_len;
                            r_num_rows <= i_cfg_num_rows;
                            r_state    <= ST_STREAM;
                            r_busy     <= 1'b1;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_accept && w_last_word) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_wen) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
